// File: rtl/corescore_rst_pkg.sv
// Shared definitions for the corescore reset sequencer: FSM state encoding
// and a width helper for counters that must be at least one bit wide.
package corescore_rst_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } rst_state_e;

  // Width needed to count 0..limit-1, never less than one bit.
  function automatic int clog2_min1(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/corescore_rst_sync.sv
// Reset synchroniser: assertion passes through asynchronously, deassertion is
// delayed by SYNC_STAGES edges of i_clk so it is clean in this domain.
module corescore_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_sync_ok
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift a constant 1 through the chain once i_rst has dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign o_sync_ok = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/corescore_reset_sequencer.sv
// Staged reset release: after the board reset is synchronised and a settle
// time has elapsed, the o_rst bits are released one at a time, lowest first.
// A soft-reset request re-runs the sequence without a full reset.
module corescore_reset_sequencer
  import corescore_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int NUM_OUTPUTS = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_soft_rst,
  output logic [NUM_OUTPUTS-1:0] o_rst,
  output logic                   o_ready,
  output logic [7:0]             o_seq_count
);

  localparam int CNT_W = clog2_min1(HOLD_CYCLES);
  localparam int GAP_W = clog2_min1(STAGE_GAP);
  localparam int IDX_W = clog2_min1(NUM_OUTPUTS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUTPUTS - 1);

  logic                   sync_ok;
  rst_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [GAP_W-1:0]       gap_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_OUTPUTS-1:0] rst_q;
  logic                   ready_q;
  logic [7:0]             seq_count_q;
  logic [7:0]             seq_count_d;
  logic [NUM_OUTPUTS-1:0] idx_mask;

  corescore_rst_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .o_sync_ok (sync_ok)
  );

  // Saturating completion counter and the one-hot mask of the bit being released.
  always_comb begin
    seq_count_d = (seq_count_q == 8'hFF) ? seq_count_q : seq_count_q + 8'd1;
    idx_mask    = NUM_OUTPUTS'(1) << idx_q;
  end

  // Sequencer FSM; all outputs are registered here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      gap_q       <= '0;
      idx_q       <= '0;
      rst_q       <= '1;
      ready_q     <= 1'b0;
      seq_count_q <= '0;
    end else if (state_q == ST_RESET) begin
      // Soft reset has no meaning until the synchroniser has settled.
      if (sync_ok) begin
        state_q <= ST_HOLD;
        cnt_q   <= '0;
      end
    end else if (i_soft_rst) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == CNT_LAST) begin
            rst_q[0] <= 1'b0;
            gap_q    <= '0;
            if (NUM_OUTPUTS == 1) begin
              state_q     <= ST_RUN;
              ready_q     <= 1'b1;
              seq_count_q <= seq_count_d;
            end else begin
              state_q <= ST_RELEASE;
              idx_q   <= IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            rst_q <= rst_q & ~idx_mask;
            gap_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q     <= ST_RUN;
              ready_q     <= 1'b1;
              seq_count_q <= seq_count_d;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: begin
          // RUN: outputs hold until a reset of either kind.
        end
      endcase
    end
  end

  assign o_rst       = rst_q;
  assign o_ready     = ready_q;
  assign o_seq_count = seq_count_q;

endmodule
